fmult_collect: RTL and testbench
================================

# fmult_collect

Downstream collector for the single-precision `fmult` pipeline in the FFT datapath. It tracks which `fmult` pipeline slots carry valid products and captures each product, with its exception flags, into a credit-protected FIFO. It presents the products as a framed valid/ready stream and aggregates the exception flags per frame. Its upstream issue logic uses `issue_ready` to throttle operands so that no in-flight product is ever dropped.

## Interface
- `LATENCY`, 11: `fmult` pipeline depth in clock edges from operand sample to result sample; must be ≥ 1.
- `DEPTH`, 16: FIFO capacity in words; power of two, ≥ 2.
- `FRAME_LEN`, 256: beats per output frame; ≥ 1.
- `clock` in 1: single clock; all logic is rising-edge.
- `aclr_n` in 1: asynchronous, active-low reset.
- `issue_valid` in 1: operands are presented to `fmult` this cycle (`fmult` runs with `clk_en`=1).
- `issue_ready` out 1: the collector can absorb one more product. An issue counts only when `issue_valid & issue_ready`.
- `result` in 32: `fmult` result.
- `nan`, `overflow`, `underflow`, `zero` in 1 each: `fmult` flags, aligned with `result`.
- `out_data` out 32: product word.
- `out_valid` out 1: `out_data` is valid.
- `out_ready` in 1: consumer accepts the beat.
- `out_last` out 1: this beat is the final beat of a frame.
- `frame_flags` out 4: {nan, overflow, underflow, zero}, OR of all beats in the frame. Valid only while `out_last & out_valid`, otherwise 0.
- `frame_count` out 16: number of completed frames; wraps modulo 2^16.

## Operation
- **Slot tracker:** a shift register of LATENCY bits.
  - Bit 0 loads the accepted-issue value each edge.
  - The tap is bit LATENCY-1.
  - When the tap is high, the edge writes {flags, `result`} (36 bits) into the FIFO.
  - An issue sampled at edge k is therefore written at edge k+LATENCY.
- **In-flight counter** (0..DEPTH): +1 on an accepted issue, -1 on a tap write. Both in the same cycle leaves it unchanged.
- **FIFO:** DEPTH×36, with registered read and write pointers and an occupancy counter (0..DEPTH).
  - A read and a write in the same cycle leave occupancy unchanged.
  - A write is never blocked.
- **Credit:** `issue_ready` = (occupancy + in-flight) < DEPTH, decoded combinationally from registers.
  - A read frees a credit from the following cycle onward.
  - By construction the FIFO can never overflow. A tap write into a full FIFO is an assertion failure in the bench.
- **Output:**
  - `out_valid` = occupancy ≠ 0; `out_data` = FIFO head.
  - A beat completes when `out_valid & out_ready`.
  - `out_valid` never drops without a handshake; data stays stable while stalled.
- **Framing:**
  - A beat index counter (0..FRAME_LEN-1) advances on each handshake.
  - `out_last` = (index == FRAME_LEN-1) & `out_valid`.
  - On the last-beat handshake the index resets to 0 and `frame_count` increments, wrapping 0xFFFF→0.
- **Flag aggregation:**
  - A sticky 4-bit register ORs in the head flags on each non-last handshake.
  - `frame_flags` = sticky | head flags during the last beat.
  - The sticky register clears on the last-beat handshake.
  - With FRAME_LEN=1, `frame_flags` = head flags.
- **Reset** (any time, including mid-operation): clears the shift register, in-flight counter, pointers, occupancy, beat index, sticky flags and `frame_count`.
  - Products issued before reset are discarded and never appear at the output.
  - The upstream `fmult` is not reset; its stale results are ignored because the tracker is clear.

## Timing
- Reset values: `issue_ready`=1; `out_valid`=0; `out_last`=0; `frame_flags`=0; `out_data`=0; `frame_count`=0.
- First-word latency: an issue at edge k into an empty FIFO gives `out_valid`=1 in the cycle after edge k+LATENCY.
- Throughput: one issue and one output beat per cycle, sustained, when `out_ready`=1.
- Maximum accepted-but-unread products: exactly DEPTH.
- The sum of in-flight count and occupancy is never greater than DEPTH.

## Test plan
- **Reset:** hold `aclr_n`=0 with random inputs. Require `issue_ready`=1 and `out_valid`, `out_last`, `frame_flags`, `frame_count` all 0, both during reset and on the first cycle after release.
- **Single product:** issue one product at edge k with `result`=0x40800000 and flags 0 aligned at edge k+11. Require `out_valid` in the cycle after edge k+11 with `out_data`=0x40800000, and deassertion after a handshake with `out_ready`=1.
- **Backpressure:** hold `out_ready`=0 and `issue_valid`=1. Require exactly 16 accepted issues before `issue_ready`=0. Release `out_ready`; require 16 words out in issue order, no loss, and `issue_ready` returning the cycle after the first read.
- **Framing, FRAME_LEN=4:** send 4 beats with `nan`=1 on beat 2 only. Require `out_last` on beat 4 only, `frame_flags`=4'b1000 there, and `frame_count` 0→1. Send the next frame with `zero`=1 on beat 4 only; require `frame_flags`=4'b0001.
- **Reset mid-flight:** make 3 issues, assert `aclr_n`=0 for 2 cycles 5 edges later, then release while upstream keeps delivering stale results. Require no `out_valid` ever and `issue_ready`=1.
- **Wrap, FRAME_LEN=1:** complete 65536 handshakes. Require `frame_count` to step 0xFFFF→0x0000 and `out_last`=1 on every beat.

Source files
------------

// File: rtl/fmult_collect.sv
// rtl/fmult_collect.sv - fmult result collector: slot tracker, credit FIFO, framed output
//
// Purpose:
//   Follows the fmult pipeline with a LATENCY-deep slot tracker so that only
//   products belonging to accepted issues are captured. Captured products and
//   their exception flags go into a DEPTH-word FIFO whose capacity is handed to
//   the issuer as credits, so a product can never arrive at a full FIFO. The
//   FIFO drains as a valid/ready stream framed in FRAME_LEN beats, with the
//   exception flags ORed over each frame and presented on the last beat.
//
// Ports:
//   clock        rising-edge clock
//   aclr_n       asynchronous active-low reset
//   issue_valid  operands presented to fmult this cycle
//   issue_ready  one more product can be absorbed (issue counts on valid & ready)
//   result       fmult product, aligned LATENCY edges after its issue
//   nan, overflow, underflow, zero
//                fmult exception flags, aligned with result
//   out_data     product word at the FIFO head (0 when out_valid is low)
//   out_valid    out_data holds a product
//   out_ready    consumer accepts the beat
//   out_last     final beat of the current frame
//   frame_flags  {nan, overflow, underflow, zero} ORed over the frame, shown on
//                the last beat only
//   frame_count  completed frames, modulo 2^16

module fmult_collect #(
  parameter int LATENCY   = 11,
  parameter int DEPTH     = 16,
  parameter int FRAME_LEN = 256
) (
  input  logic        clock,
  input  logic        aclr_n,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [31:0] result,
  input  logic        nan,
  input  logic        overflow,
  input  logic        underflow,
  input  logic        zero,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic [3:0]  frame_flags,
  output logic [15:0] frame_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int IW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(FRAME_LEN - 1);
  localparam logic [CW:0]   DEPTH_SUM = (CW + 1)'(DEPTH);

  // Slot tracker: one bit per fmult pipeline stage, set when that stage
  // carries an accepted issue.
  logic [LATENCY-1:0] slot_q, slot_d;

  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [3:0]    sticky_q, sticky_d;
  logic [15:0]   frame_count_q, frame_count_d;

  // FIFO storage; contents need no reset because occupancy gates every read.
  logic [35:0] mem_q [DEPTH];
  logic [35:0] wr_word;

  logic        accept;
  logic        tap_wr;
  logic        rd_hs;
  logic        is_last;
  logic [35:0] head;
  logic [3:0]  head_flags;
  logic [CW:0] credit_sum;

  // Credits are decoded from registers only, so a read returns its credit on
  // the cycle after the handshake.
  assign credit_sum  = {1'b0, occ_q} + {1'b0, inflight_q};
  assign issue_ready = credit_sum < DEPTH_SUM;
  assign accept      = issue_valid & issue_ready;

  assign tap_wr  = slot_q[LATENCY-1];
  assign wr_word = {nan, overflow, underflow, zero, result};

  assign out_valid  = occ_q != '0;
  assign rd_hs      = out_valid & out_ready;
  assign head       = mem_q[rd_ptr_q];
  assign out_data   = out_valid ? head[31:0] : 32'h0;
  assign head_flags = out_valid ? head[35:32] : 4'h0;

  assign is_last     = idx_q == LAST_IDX;
  assign out_last    = is_last & out_valid;
  assign frame_flags = out_last ? (sticky_q | head_flags) : 4'h0;
  assign frame_count = frame_count_q;

  generate
    if (LATENCY == 1) begin : g_slot_single
      always_comb begin
        slot_d = accept;
      end
    end else begin : g_slot_chain
      always_comb begin
        slot_d = {slot_q[LATENCY-2:0], accept};
      end
    end
  endgenerate

  always_comb begin
    inflight_d = inflight_q;
    case ({accept, tap_wr})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase

    occ_d = occ_q;
    case ({tap_wr, rd_hs})
      2'b10:   occ_d = occ_q + CW'(1);
      2'b01:   occ_d = occ_q - CW'(1);
      default: occ_d = occ_q;
    endcase

    wr_ptr_d = tap_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = rd_hs  ? rd_ptr_q + AW'(1) : rd_ptr_q;
  end

  // Framing: the sticky register holds flags of beats already sent in this
  // frame; the last beat's own flags are merged combinationally on output.
  always_comb begin
    idx_d         = idx_q;
    sticky_d      = sticky_q;
    frame_count_d = frame_count_q;
    if (rd_hs) begin
      if (is_last) begin
        idx_d         = '0;
        sticky_d      = 4'h0;
        frame_count_d = frame_count_q + 16'd1;
      end else begin
        idx_d    = idx_q + IW'(1);
        sticky_d = sticky_q | head_flags;
      end
    end
  end

  always_ff @(posedge clock or negedge aclr_n) begin
    if (!aclr_n) begin
      slot_q        <= '0;
      inflight_q    <= '0;
      occ_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      idx_q         <= '0;
      sticky_q      <= 4'h0;
      frame_count_q <= 16'h0;
    end else begin
      slot_q        <= slot_d;
      inflight_q    <= inflight_d;
      occ_q         <= occ_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      idx_q         <= idx_d;
      sticky_q      <= sticky_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (tap_wr) begin
      mem_q[wr_ptr_q] <= wr_word;
    end
  end

endmodule

// File: tb/tb_fmult_collect.sv
// tb/tb_fmult_collect.sv - directed self-checking bench for fmult_collect

module tb_fmult_collect;

  localparam int LAT = 11;
  localparam int DEP = 16;

  logic        clock = 1'b0;
  logic        aclr_n;
  logic        issue_valid;
  logic        out_ready;
  logic [31:0] op_data;
  logic [3:0]  op_flags;

  logic [31:0] result;
  logic        nan, overflow, underflow, zero;

  logic        ir4, ov4, ol4;
  logic [31:0] od4;
  logic [3:0]  ff4;
  logic [15:0] fc4;

  logic        ir1, ov1, ol1;
  logic [31:0] od1;
  logic [3:0]  ff1;
  logic [15:0] fc1;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  // Upstream fmult stand-in: a free-running, never-reset delay line of LAT
  // stages carrying the operand tag and flags to the result port.
  logic [35:0] pipe [LAT];
  always @(posedge clock) begin
    pipe[0] <= {op_flags, op_data};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign {nan, overflow, underflow, zero, result} = pipe[LAT-1];

  fmult_collect #(.LATENCY(LAT), .DEPTH(DEP), .FRAME_LEN(4)) dut4 (
    .clock(clock), .aclr_n(aclr_n),
    .issue_valid(issue_valid), .issue_ready(ir4),
    .result(result), .nan(nan), .overflow(overflow), .underflow(underflow), .zero(zero),
    .out_data(od4), .out_valid(ov4), .out_ready(out_ready), .out_last(ol4),
    .frame_flags(ff4), .frame_count(fc4)
  );

  fmult_collect #(.LATENCY(LAT), .DEPTH(DEP), .FRAME_LEN(1)) dut1 (
    .clock(clock), .aclr_n(aclr_n),
    .issue_valid(issue_valid), .issue_ready(ir1),
    .result(result), .nan(nan), .overflow(overflow), .underflow(underflow), .zero(zero),
    .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_last(ol1),
    .frame_flags(ff1), .frame_count(fc1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clock);
    aclr_n = 1'b0; issue_valid = 1'b0; out_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    aclr_n = 1'b1;
    @(negedge clock);
  endtask

  // Issue four back-to-back beats; flag_val rides on beat flag_beat only.
  task automatic send_frame(input logic [31:0] base, input int flag_beat, input logic [3:0] flag_val);
    for (int b = 0; b < 4; b++) begin
      op_data     = base + 32'(b);
      op_flags    = (b == flag_beat) ? flag_val : 4'h0;
      issue_valid = 1'b1;
      @(negedge clock);
    end
    issue_valid = 1'b0;
    op_flags    = 4'h0;
    for (int i = 0; i < LAT + 2; i++) @(negedge clock);
  endtask

  task automatic drain_frame(input logic [31:0] base, input int flag_beat, input logic [3:0] flag_val,
                             input logic [3:0] exp_frame, input logic [15:0] fc_before);
    for (int b = 0; b < 4; b++) begin
      chk("frm_valid", 32'(ov4), 32'd1);
      chk("frm_data", od4, base + 32'(b));
      chk("frm_last", 32'(ol4), (b == 3) ? 32'd1 : 32'd0);
      chk("frm_flags", 32'(ff4), (b == 3) ? 32'(exp_frame) : 32'd0);
      chk("len1_flags", 32'(ff1), (b == flag_beat) ? 32'(flag_val) : 32'd0);
      if (b == 3) chk("frm_count_before", 32'(fc4), 32'(fc_before));
      out_ready = 1'b1;
      @(negedge clock);
    end
    out_ready = 1'b0;
    chk("frm_count_after", 32'(fc4), 32'(fc_before) + 32'd1);
    chk("frm_empty", 32'(ov4), 32'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

  initial begin
    int acc, first_low, bad, hs, bad_last, bad_fc;
    logic [15:0] fc_pre, fc_post;

    aclr_n = 1'b0; issue_valid = 1'b0; out_ready = 1'b0;
    op_data = 32'h0; op_flags = 4'h0;

    // Reset with random inputs, then the first cycle after release.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      issue_valid = 1'($urandom); out_ready = 1'($urandom);
      op_data = $urandom; op_flags = 4'($urandom);
    end
    #1;
    chk("rst_ready", 32'(ir4), 32'd1);
    chk("rst_valid", 32'(ov4), 32'd0);
    chk("rst_last", 32'(ol4), 32'd0);
    chk("rst_flags", 32'(ff4), 32'd0);
    chk("rst_count", 32'(fc4), 32'd0);
    chk("rst_data", od4, 32'd0);
    @(negedge clock);
    aclr_n = 1'b1; issue_valid = 1'b0; out_ready = 1'b0; op_data = 32'h0; op_flags = 4'h0;
    @(negedge clock);
    chk("post_rst_ready", 32'(ir4), 32'd1);
    chk("post_rst_valid", 32'(ov4), 32'd0);
    chk("post_rst_last", 32'(ol4), 32'd0);
    chk("post_rst_flags", 32'(ff4), 32'd0);
    chk("post_rst_count", 32'(fc4), 32'd0);

    // Single product: visible exactly after the 11th edge following its issue.
    issue_valid = 1'b1; op_data = 32'h40800000; op_flags = 4'h0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clock);
      if (i == 1) begin
        issue_valid = 1'b0; op_data = 32'hDEADBEEF; op_flags = 4'hF;
      end
      if (i == 11) chk("single_not_early", 32'(ov4), 32'd0);
    end
    chk("single_valid", 32'(ov4), 32'd1);
    chk("single_data", od4, 32'h40800000);
    out_ready = 1'b1;
    @(negedge clock);
    chk("single_drained", 32'(ov4), 32'd0);
    out_ready = 1'b0; op_flags = 4'h0;

    // Backpressure: exactly DEP issues accepted, then drained in order.
    acc = 0; first_low = -1;
    issue_valid = 1'b1; op_data = 32'h1000;
    for (int c = 0; c < 40; c++) begin
      if (ir4) acc++;
      else if (first_low < 0) first_low = c;
      @(negedge clock);
      op_data = 32'h1000 + 32'(acc);
    end
    chk("bp_accepted", 32'(acc), 32'd16);
    chk("bp_first_block", 32'(first_low), 32'd16);
    chk("bp_ready_low", 32'(ir4), 32'd0);
    issue_valid = 1'b0;
    for (int i = 0; i < 16; i++) begin
      chk("bp_data", od4, 32'h1000 + 32'(i));
      out_ready = 1'b1;
      @(negedge clock);
      if (i == 0) chk("bp_ready_back", 32'(ir4), 32'd1);
    end
    out_ready = 1'b0;
    chk("bp_empty", 32'(ov4), 32'd0);

    // Framing with FRAME_LEN=4 (the FRAME_LEN=1 instance checks per-beat flags).
    do_reset();
    send_frame(32'h2000, 1, 4'b1000);
    drain_frame(32'h2000, 1, 4'b1000, 4'b1000, 16'd0);
    send_frame(32'h2100, 3, 4'b0001);
    drain_frame(32'h2100, 3, 4'b0001, 4'b0001, 16'd1);

    // Reset while three products are in flight; stale results must vanish.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue_valid = 1'b1; op_data = 32'h3000 + 32'(i);
      @(negedge clock);
    end
    issue_valid = 1'b0;
    for (int i = 0; i < 5; i++) @(negedge clock);
    bad = 0;
    aclr_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      if (ov4 !== 1'b0 || ir4 !== 1'b1) bad++;
    end
    aclr_n = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clock);
      if (ov4 !== 1'b0 || ir4 !== 1'b1) bad++;
    end
    chk("midrst_quiet_cycles_bad", 32'(bad), 32'd0);
    chk("midrst_count", 32'(fc4), 32'd0);
    out_ready = 1'b0;

    // frame_count wrap with FRAME_LEN=1: every beat is last.
    do_reset();
    issue_valid = 1'b1; out_ready = 1'b1; op_data = 32'h0; op_flags = 4'h0;
    hs = 0; bad_last = 0; bad_fc = 0; fc_pre = 16'h0;
    for (int c = 0; c < 70000 && hs < 65536; c++) begin
      @(negedge clock);
      if (fc1 !== 16'(hs)) bad_fc++;
      if (ov1) begin
        if (ol1 !== 1'b1) bad_last++;
        if (hs == 65535) fc_pre = fc1;
        hs++;
      end
    end
    @(negedge clock);
    fc_post = fc1;
    issue_valid = 1'b0; out_ready = 1'b0;
    chk("wrap_handshakes", 32'(hs), 32'd65536);
    chk("wrap_last_bad_beats", 32'(bad_last), 32'd0);
    chk("wrap_count_bad_cycles", 32'(bad_fc), 32'd0);
    chk("wrap_before", 32'(fc_pre), 32'h0000FFFF);
    chk("wrap_after", 32'(fc_post), 32'h00000000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
